// File: rtl/wb_mem_responder_if.sv
// rtl/wb_mem_responder_if.sv - memory-port bus between picorv32 master and the memory responder
interface wb_mem_responder_if;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - word RAM responder with byte lanes, wait states and a firmware exit register
module wb_mem_responder #(
    parameter int          MEM_ADDR_BITS = 17,
    parameter int          WAIT_STATES   = 1,
    parameter logic [29:0] EXIT_WADR     = 30'h0400_0001,
    parameter logic [31:0] EXIT_CODE     = 32'h0000_00AD,
    parameter              INIT_FILE     = ""
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    wb_mem_responder_if.slave   bus,
    output logic                o_done,
    output logic                o_err,
    output logic [31:0]         o_cycles
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_wcnt;
    logic [29:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic        r_ack;
    logic [31:0] r_rdt;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_cycles;
    logic [31:0] r_exit;
    logic [31:0] r_mem [0:(2**MEM_ADDR_BITS)-1];

    logic                     w_capture;
    logic                     w_commit;
    logic                     w_is_exit;
    logic                     w_in_range;
    logic [MEM_ADDR_BITS-1:0] w_idx;
    logic [31:0]              w_mask;
    logic [31:0]              w_exit_new;

    // The cycle that shows ack never captures, so a held cyc still gets an idle gap.
    assign w_capture  = (r_state == S_IDLE) && bus.cyc && !r_ack;
    assign w_commit   = (r_state == S_ACK);
    assign w_is_exit  = (r_adr == EXIT_WADR);
    assign w_in_range = ((r_adr >> MEM_ADDR_BITS) == 30'd0);
    assign w_idx      = r_adr[MEM_ADDR_BITS-1:0];
    assign w_mask     = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
    assign w_exit_new = (r_exit & ~w_mask) | (r_dat & w_mask);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_capture) w_next = (WS == 4'd0) ? S_ACK : S_WAIT;
            S_WAIT: begin
                if (!bus.cyc)           w_next = S_IDLE;
                else if (r_wcnt <= 4'd1) w_next = S_ACK;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state  <= S_IDLE;
            r_wcnt   <= 4'd0;
            r_adr    <= 30'd0;
            r_dat    <= 32'd0;
            r_sel    <= 4'd0;
            r_we     <= 1'b0;
            r_ack    <= 1'b0;
            r_rdt    <= 32'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cycles <= 32'd0;
            r_exit   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_commit;
            if (!r_done) r_cycles <= r_cycles + 32'd1;
            if (w_capture) begin
                r_adr  <= bus.adr;
                r_dat  <= bus.dat;
                r_sel  <= bus.sel;
                r_we   <= bus.we;
                r_wcnt <= WS;
            end else if (r_state == S_WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_commit) begin
                if (w_is_exit)       r_rdt <= r_exit;
                else if (w_in_range) r_rdt <= r_mem[w_idx];
                else                 r_rdt <= 32'd0;
                if (w_is_exit && r_we) begin
                    r_exit <= w_exit_new;
                    if (w_exit_new == EXIT_CODE) r_done <= 1'b1;
                end
                if (!w_is_exit && !w_in_range) r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_commit && r_we && w_in_range && !w_is_exit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_sel[i]) r_mem[w_idx][8*i +: 8] <= r_dat[8*i +: 8];
            end
        end
    end

    assign bus.ack  = r_ack;
    assign bus.rdt  = r_rdt;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_cycles = r_cycles;
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - self-checking bench for wb_mem_responder
module tb_wb_mem_responder;
    localparam int          AB     = 10;
    localparam logic [29:0] EXIT_A = 30'h0400_0001;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    wb_mem_responder_if bus ();
    wb_mem_responder_if bus_z ();
    wb_mem_responder_if bus_t ();

    assign bus_z.adr = bus.adr;  assign bus_t.adr = bus.adr;
    assign bus_z.dat = bus.dat;  assign bus_t.dat = bus.dat;
    assign bus_z.sel = bus.sel;  assign bus_t.sel = bus.sel;
    assign bus_z.we  = bus.we;   assign bus_t.we  = bus.we;
    assign bus_z.cyc = bus.cyc;  assign bus_t.cyc = bus.cyc;

    logic        done0, err0, done1, err1, done2, err2;
    logic [31:0] cyc0, cyc1, cyc2;

    wb_mem_responder #(.MEM_ADDR_BITS(AB), .WAIT_STATES(1)) u_ws1 (
        .i_clk(clk), .i_resetn(resetn), .bus(bus), .o_done(done0), .o_err(err0), .o_cycles(cyc0));
    wb_mem_responder #(.MEM_ADDR_BITS(AB), .WAIT_STATES(0)) u_ws0 (
        .i_clk(clk), .i_resetn(resetn), .bus(bus_z), .o_done(done1), .o_err(err1), .o_cycles(cyc1));
    wb_mem_responder #(.MEM_ADDR_BITS(AB), .WAIT_STATES(3)) u_ws3 (
        .i_clk(clk), .i_resetn(resetn), .bus(bus_t), .o_done(done2), .o_err(err2), .o_cycles(cyc2));

    logic [2:0]  acks;
    logic [31:0] rdts [3];
    assign acks    = {bus_t.ack, bus_z.ack, bus.ack};
    assign rdts[0] = bus.rdt;
    assign rdts[1] = bus_z.rdt;
    assign rdts[2] = bus_t.rdt;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: sparse word store, exit register and sticky flags.
    logic [31:0] mem_m [int];
    logic [31:0] exit_m;
    bit          exit_known = 0;
    bit          err_m = 0;
    bit          done_m = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic model_apply(input logic w, input logic [29:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] exp, output bit known);
        int idx;
        known = 1;
        exp   = 32'd0;
        if (a == EXIT_A) begin
            if (w) begin
                if (s == 4'hF) exit_known = 1;
                exit_m = merge(exit_m, d, s);
                if (exit_known && exit_m == 32'h0000_00AD) done_m = 1;
            end
            exp = exit_m; known = exit_known;
        end else if (a >= 30'(2**AB)) begin
            err_m = 1;
        end else begin
            idx = int'(a);
            if (w) begin
                if (mem_m.exists(idx))  mem_m[idx] = merge(mem_m[idx], d, s);
                else if (s == 4'hF)     mem_m[idx] = d;
            end
            known = mem_m.exists(idx);
            if (known) exp = mem_m[idx];
        end
    endtask

    task automatic xfer(input int k, input logic w, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat,
                        output logic dn, output logic [31:0] cy, output logic ack_after);
        @(negedge clk);
        bus.cyc = 1'b1; bus.we = w; bus.adr = a; bus.dat = d; bus.sel = s;
        lat = 99; rd = 32'd0; dn = 1'b0; cy = 32'd0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (acks[k]) begin
                lat = n; rd = rdts[k]; dn = done0; cy = cyc0;
                break;
            end
        end
        bus.cyc = 1'b0; bus.we = 1'b0;
        @(negedge clk);
        ack_after = acks[k];
    endtask

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] rd, cy, cy_frozen, exp;
    logic        dn, aa;
    int          lat, nack, consec;
    bit          known, prev;
    int          lat_exp [3];

    initial begin
        bus.cyc = 1'b1; bus.we = 1'b1; bus.adr = 30'd5; bus.dat = 32'hFFFF_FFFF; bus.sel = 4'hF;
        lat_exp[0] = 2; lat_exp[1] = 1; lat_exp[2] = 4;

        tbl[0]  = '{1'b1, 30'd5,     32'h1234_5678, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 30'd5,     32'h0,         4'h0, 32'h1234_5678};
        tbl[2]  = '{1'b1, 30'd5,     32'hAABB_CCDD, 4'h5, 32'h0};
        tbl[3]  = '{1'b0, 30'd5,     32'h0,         4'hF, 32'h12BB_56DD};
        tbl[4]  = '{1'b1, 30'd5,     32'hFFFF_FFFF, 4'h0, 32'h0};
        tbl[5]  = '{1'b0, 30'd5,     32'h0,         4'h3, 32'h12BB_56DD};
        tbl[6]  = '{1'b1, 30'd9,     32'h0,         4'hF, 32'h0};
        tbl[7]  = '{1'b1, 30'd9,     32'hCAFE_F00D, 4'hA, 32'h0};
        tbl[8]  = '{1'b0, 30'd9,     32'h0,         4'h0, 32'hCA00_F000};
        tbl[9]  = '{1'b1, 30'h3FF,   32'h1357_9BDF, 4'hF, 32'h0};
        tbl[10] = '{1'b0, 30'h3FF,   32'h0,         4'hF, 32'h1357_9BDF};
        tbl[11] = '{1'b1, 30'd0,     32'h0102_0304, 4'hF, 32'h0};

        // Reset held with a live request
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {31'd0, bus.ack}, 32'd0);
        check("reset_rdt", bus.rdt, 32'd0);
        check("reset_done", {31'd0, done0}, 32'd0);
        check("reset_err", {31'd0, err0}, 32'd0);
        check("reset_cycles", cyc0, 32'd0);
        bus.cyc = 1'b0; bus.we = 1'b0;
        resetn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("cycles_count", cyc0, 32'(i));
        end

        // Abort by dropping cyc, then by a reset pulse
        xfer(0, 1'b1, 30'd7, 32'h7777_7777, 4'hF, rd, lat, dn, cy, aa);
        model_apply(1'b1, 30'd7, 32'h7777_7777, 4'hF, exp, known);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            bus.cyc = 1'b1; bus.we = 1'b1; bus.adr = 30'd7; bus.dat = 32'hDEAD_BEEF; bus.sel = 4'hF;
            @(posedge clk); @(negedge clk);
            if (p == 1) resetn = 1'b0;
            bus.cyc = 1'b0; bus.we = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            nack = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); @(negedge clk);
                if (bus.ack) nack++;
            end
            check("abort_no_ack", 32'(nack), 32'd0);
            xfer(0, 1'b0, 30'd7, 32'd0, 4'hF, rd, lat, dn, cy, aa);
            check("abort_unchanged", rd, 32'h7777_7777);
        end

        // Table of single transfers on the 1-wait-state responder
        foreach (tbl[i]) begin
            xfer(0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, lat, dn, cy, aa);
            model_apply(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, exp, known);
            check("tbl_latency", 32'(lat), 32'd2);
            check("tbl_ack_width", {31'd0, aa}, 32'd0);
            if (!tbl[i].we) check("tbl_rdt", rd, tbl[i].exp);
        end

        // Exit register
        xfer(0, 1'b1, EXIT_A, 32'h0000_00AC, 4'hF, rd, lat, dn, cy, aa);
        check("exit_ac_done", {31'd0, dn}, 32'd0);
        xfer(0, 1'b0, EXIT_A, 32'd0, 4'hF, rd, lat, dn, cy, aa);
        check("exit_readback", rd, 32'h0000_00AC);
        xfer(0, 1'b1, EXIT_A, 32'h0000_00AD, 4'hF, rd, lat, dn, cy_frozen, aa);
        check("exit_done", {31'd0, dn}, 32'd1);
        repeat (3) @(posedge clk);
        xfer(0, 1'b0, 30'd5, 32'd0, 4'hF, rd, lat, dn, cy, aa);
        check("after_done_ack", 32'(lat), 32'd2);
        check("after_done_rdt", rd, 32'h12BB_56DD);
        check("cycles_frozen", cyc0, cy_frozen);

        // Out of range: first address past the RAM aliases word 0 if wrongly decoded
        check("err_before", {31'd0, err0}, 32'd0);
        xfer(0, 1'b1, 30'(2**AB), 32'hFFFF_FFFF, 4'hF, rd, lat, dn, cy, aa);
        xfer(0, 1'b0, 30'(2**AB), 32'd0, 4'hF, rd, lat, dn, cy, aa);
        check("oor_rdt", rd, 32'd0);
        check("oor_err", {31'd0, err0}, 32'd1);
        check("oor_ack", 32'(lat), 32'd2);
        xfer(0, 1'b0, 30'd0, 32'd0, 4'hF, rd, lat, dn, cy, aa);
        check("oor_no_alias", rd, 32'h0102_0304);

        // Reset clears flags but keeps RAM; then random traffic against the model
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        check("rst2_done", {31'd0, done0}, 32'd0);
        check("rst2_err", {31'd0, err0}, 32'd0);
        exit_known = 0; err_m = 0; done_m = 0;
        for (int t = 0; t < 200; t++) begin
            logic [29:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            logic        w;
            int          r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = 30'($urandom_range(0, 15));
            else if (r == 7) a = 30'h3FF;
            else if (r == 8) a = 30'(2**AB + $urandom_range(0, 100));
            else             a = EXIT_A;
            w = 1'($urandom);
            d = $urandom;
            s = 4'($urandom);
            if (a == EXIT_A) begin d[31] = 1'b1; s = 4'hF; end
            xfer(0, w, a, d, s, rd, lat, dn, cy, aa);
            model_apply(w, a, d, s, exp, known);
            check("rnd_latency", 32'(lat), 32'd2);
            if (!w && known) check("rnd_rdt", rd, exp);
            check("rnd_err", {31'd0, err0}, {31'd0, err_m});
            check("rnd_done", {31'd0, done0}, {31'd0, done_m});
        end

        // Latency sweep and held-cyc idle gap on all three wait-state settings
        for (int k = 0; k < 3; k++) begin
            xfer(k, 1'b1, 30'd20, 32'h5555_AAAA + 32'(k), 4'hF, rd, lat, dn, cy, aa);
            check("sweep_wr_latency", 32'(lat), 32'(lat_exp[k]));
            xfer(k, 1'b0, 30'd20, 32'd0, 4'hF, rd, lat, dn, cy, aa);
            check("sweep_rd_latency", 32'(lat), 32'(lat_exp[k]));
            check("sweep_rdt", rd, 32'h5555_AAAA + 32'(k));
            @(negedge clk);
            bus.cyc = 1'b1; bus.we = 1'b0; bus.adr = 30'd20;
            nack = 0; consec = 0; prev = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); @(negedge clk);
                if (acks[k]) begin nack++; if (prev) consec++; end
                prev = acks[k];
            end
            bus.cyc = 1'b0;
            repeat (6) @(negedge clk);
            check("held_multi_ack", {31'd0, nack >= 2}, 32'd1);
            check("held_idle_gap", 32'(consec), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
